// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run / single-step / halt sequencer for the pipelined MIPS core.
// Replaces the divided CPU clock with a one-clk clock-enable pulse (cpu_ce) on
// the board clock, adds a cycle-count breakpoint and a stretched core reset.
module cpu_run_ctrl #(
  parameter int DIV_RATIO   = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 4,
  parameter int AUTO_RUN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [CNT_W-1:0] bp_cycle,
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } run_state_t;

  localparam int DIV_W = $clog2(DIV_RATIO);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  // Button synchroniser chain; bit 0 = run, bit 1 = step, bit 2 = halt.
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       sync_d [SYNC_STAGES];
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       btn_p;
  logic             run_p, step_p, halt_p;

  logic [DIV_W-1:0] div_q, div_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  run_state_t       state_q, state_d;

  logic             running;
  logic             ce;
  logic             bp_hit;

  // Shift raw button levels through the synchroniser and keep one more stage
  // of history so a rising edge can be detected on the synchronised level.
  always_comb begin
    sync_d[0] = {halt_req, step_req, run_req};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign btn_p  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign run_p  = btn_p[0];
  assign step_p = btn_p[1];
  assign halt_p = btn_p[2];

  // The enable is a pure decode of registered state so it never glitches from inputs.
  assign running   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ce        = running && (div_q == DIV_LAST) && !cpu_rst_q;
  assign count_inc = count_q + CNT_W'(1);
  // The breakpoint compares the count as it will be after this pulse.
  assign bp_hit    = ce && bp_en && (count_inc == bp_cycle);
  assign count_d   = ce ? count_inc : count_q;

  // Reset stretch and run-state transitions (halt > step > run priority).
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    cpu_rst_d = cpu_rst_q;
    state_d   = state_q;
    if (cpu_rst_q) begin
      // Buttons are ignored until the core comes out of reset.
      if (rst_cnt_q == RST_LAST) begin
        cpu_rst_d = 1'b0;
        state_d   = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
      end else begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
    end else begin
      case (state_q)
        ST_HALT, ST_BRK: begin
          if (halt_p) begin
            state_d = ST_HALT;
          end else if (step_p) begin
            state_d = ST_STEP;
          end else if (run_p) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_p) begin
            state_d = ST_HALT;
          end else if (bp_hit) begin
            state_d = ST_BRK;
          end
        end
        ST_STEP: begin
          // Either the single pulse has just been issued or the step was aborted.
          if (halt_p || ce) begin
            state_d = ST_HALT;
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  // Prescaler advances only while staying in RUN/STEP; any entry or stop zeroes it.
  always_comb begin
    div_d = '0;
    if (running && (state_d == state_q) && (div_q != DIV_LAST)) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // All state registers; reset clears everything and holds the core in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      div_q     <= '0;
      rst_cnt_q <= '0;
      cpu_rst_q <= 1'b1;
      count_q   <= '0;
      state_q   <= ST_HALT;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q    <= prev_d;
      div_q     <= div_d;
      rst_cnt_q <= rst_cnt_d;
      cpu_rst_q <= cpu_rst_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

  assign cpu_ce      = ce;
  assign cpu_rst     = cpu_rst_q;
  assign cycle_count = count_q;
  assign state       = state_q;

endmodule
